// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive/transmit blocks.
// Latency: n/a (types, constants and a decode helper only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  // Register-field encoding 3 is reserved and behaves as "no parity".
  function automatic parity_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running 16x oversample tick generator.
// Latency: o_tick is high for one clock every i_div+1 clocks (every clock when i_div = 0).
// Backpressure: none; the tick is never stalled.
// Ports: i_clk, i_reset (async, active-high), i_div (reload value), o_tick (one-cycle strobe).
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] cnt_q;

  // >= rather than == so a divider that shrinks below the running count
  // reloads straight away instead of wrapping through the whole range.
  assign o_tick = (cnt_q >= i_div);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (o_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: 16x-oversampling UART receiver, run-time divider/parity/stop-bit count, break/overrun detect.
// Latency: o_valid rises 1 clock after the first stop-bit sample tick.
// Backpressure: one-word valid/ready holding register; a word completing while full and not accepted is dropped and sets o_overrun.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN -- each bit is the 2-of-3 vote of the samples at ticks 7/8/9.
// Ports: i_clk, i_reset (async active-high), i_rx (async serial in), i_div/i_parity/i_stop2 (latched at frame start),
//        o_data/o_valid/i_ready (holding register), o_parity_err/o_frame_err (qualify o_data), o_break,
//        o_overrun/i_clr_overrun (sticky drop flag), o_busy (frame in progress).
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx,
  input  logic [DIV_WIDTH-1:0]  i_div,
  input  logic [1:0]            i_parity,
  input  logic                  i_stop2,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_overrun,
  input  logic                  i_clr_overrun,
  output logic                  o_busy
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  // Vote window is ticks 7..9, so the start decision lands on tick 9; later
  // bits are 16 ticks apart from there, which keeps every window bit-centred.
  localparam logic [3:0] START_DEC = 4'(MID_TICK + 2);
`else
  localparam logic [3:0] START_DEC = 4'(MID_TICK);
`endif

  // ---------------- input synchroniser ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  // Filled with 1s so the idle line level is seen straight out of reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
    end
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  // ---------------- frame configuration ----------------
  logic [DIV_WIDTH-1:0] div_q;
  parity_t              par_q;
  logic                 stop2_q;
  logic                 cfg_ld;
  logic                 tick;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_q   <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
    end else if (cfg_ld) begin
      div_q   <= i_div;
      par_q   <= decode_parity(i_parity);
      stop2_q <= i_stop2;
    end
  end

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_div   (div_q),
    .o_tick  (tick)
  );

  // ---------------- bit decision ----------------
  logic bit_val;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Shifts on every tick, so at a decision tick it holds the two previous samples.
  logic [1:0] vote_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vote_q <= '1;
    end else if (tick) begin
      vote_q <= {vote_q[0], rx_s};
    end
  end
  assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // ---------------- receive FSM ----------------
  rx_state_t             state_q, state_d;
  logic [3:0]            tcnt_q, tcnt_d;
  logic [3:0]            bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_err_q, par_err_d;
  logic                  word_done;
  logic                  frame_err;
  logic                  brk_set;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      sh_q      <= '0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      sh_q      <= sh_d;
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    sh_d      = sh_q;
    par_bit_d = par_bit_q;
    par_err_d = par_err_q;
    cfg_ld    = 1'b0;
    word_done = 1'b0;
    frame_err = 1'b0;
    brk_set   = 1'b0;

    // 4-bit count wraps 15 -> 0 by itself, giving one bit every 16 ticks.
    if (tick) begin
      tcnt_d = tcnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        // After a break the line must be seen high before a new frame can start.
        if (!rx_s && !o_break) begin
          state_d   = START;
          tcnt_d    = '0;
          cfg_ld    = 1'b1;
          par_bit_d = 1'b0;
          par_err_d = 1'b0;
        end
      end
      START: begin
        if (tick && tcnt_q == START_DEC) begin
          if (bit_val) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            tcnt_d  = '0;
            bcnt_d  = '0;
          end
        end
      end
      DATA: begin
        if (tick && tcnt_q == LAST_TICK) begin
          sh_d   = {bit_val, sh_q[DATA_WIDTH-1:1]};
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == LAST_BIT) begin
            state_d = (par_q == PAR_NONE) ? STOP : PARITY;
          end
        end
      end
      PARITY: begin
        if (tick && tcnt_q == LAST_TICK) begin
          par_bit_d = bit_val;
          par_err_d = ((^sh_q) ^ bit_val) != (par_q == PAR_ODD);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick && tcnt_q == LAST_TICK) begin
          word_done = 1'b1;
          frame_err = !bit_val;
          brk_set   = !bit_val && (sh_q == '0) && !par_bit_q;
          state_d   = stop2_q ? STOP2 : IDLE;
        end
      end
      STOP2: begin
        if (tick && tcnt_q == LAST_TICK) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- holding register and status ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
      o_break      <= 1'b0;
    end else begin
      if (word_done && (!o_valid || i_ready)) begin
        o_data       <= sh_q;
        o_parity_err <= par_err_q;
        o_frame_err  <= frame_err;
        o_valid      <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid      <= 1'b0;
        o_parity_err <= 1'b0;
        o_frame_err  <= 1'b0;
      end

      // Setting has priority over a coincident clear so no drop is lost.
      if (word_done && o_valid && !i_ready) begin
        o_overrun <= 1'b1;
      end else if (i_clr_overrun) begin
        o_overrun <= 1'b0;
      end

      if (brk_set) begin
        o_break <= 1'b1;
      end else if (rx_s) begin
        o_break <= 1'b0;
      end
    end
  end

  assign o_busy = (state_q != IDLE);

endmodule
